// File: rtl/prmcu_uart_rx_os.sv
// Oversampling UART receiver (16 ticks per bit, 2-of-3 majority vote at ticks 7/8/9)
// with a first-word-fall-through receive FIFO and a sticky overrun flag.
module prmcu_uart_rx_os #(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_en,
  input  logic [3:0]                    n_data_bits_i,
  input  logic [1:0]                    parity_mode_i,
  input  logic [1:0]                    n_stop_bits_i,
  input  logic [DIV_W-1:0]              clk_divider_i,
  input  logic                          rx_i,
  output logic [8:0]                    out_dat_o,
  output logic [2:0]                    out_err_o,
  output logic                          out_vld_o,
  input  logic                          out_rdy_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overrun_o,
  input  logic                          clr_overrun_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t           r_state, w_state_next;
  logic             r_rx_meta, r_rx_sync, r_rx_prev;
  logic [DIV_W-1:0] r_div_cnt;
  logic [3:0]       r_tick_cnt;
  logic             r_s7, r_s8;
  logic [3:0]       r_nbits, r_bit_cnt;
  logic             r_par_en, r_par_odd, r_two_stop, r_stop_cnt;
  logic [8:0]       r_data;
  logic             r_par_acc, r_par_bit, r_par_err, r_frm;

  logic w_start_det, w_run, w_tick, w_t7, w_t8, w_t9, w_t15, w_maj;
  logic w_last_stop, w_push, w_frm, w_brk;
  logic [11:0] w_word;

  // Synchronizer flops idle high so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx_i;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_start_det = (r_state == S_IDLE) && rx_en && r_rx_prev && !r_rx_sync;
  assign w_run       = rx_en && (r_state != S_IDLE);
  assign w_tick      = w_run && (r_div_cnt == clk_divider_i);
  assign w_t7        = w_tick && (r_tick_cnt == 4'd7);
  assign w_t8        = w_tick && (r_tick_cnt == 4'd8);
  assign w_t9        = w_tick && (r_tick_cnt == 4'd9);
  assign w_t15       = w_tick && (r_tick_cnt == 4'd15);
  assign w_maj       = (r_s7 & r_s8) | (r_s7 & r_rx_sync) | (r_s8 & r_rx_sync);
  assign w_last_stop = (r_stop_cnt == r_two_stop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt  <= '0;
      r_tick_cnt <= '0;
    end else if (w_start_det) begin
      r_div_cnt  <= '0;
      r_tick_cnt <= '0;
    end else if (w_run) begin
      if (w_tick) begin
        r_div_cnt  <= '0;
        r_tick_cnt <= r_tick_cnt + 4'd1;
      end else begin
        r_div_cnt  <= r_div_cnt + 1'b1;
      end
    end else begin
      r_div_cnt  <= '0;
      r_tick_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start_det) w_state_next = S_START;
      S_START: begin
        if (w_t9 && w_maj) w_state_next = S_IDLE;
        else if (w_t15)    w_state_next = S_DATA;
      end
      S_DATA:   if (w_t15 && (r_bit_cnt == r_nbits)) w_state_next = r_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (w_t15) w_state_next = S_STOP;
      S_STOP:   if (w_t9 && w_last_stop) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
    if (!rx_en) w_state_next = S_IDLE;
  end

  always_comb begin
    w_push = (r_state == S_STOP) && w_t9 && w_last_stop;
    w_frm  = r_frm | ~w_maj;
    w_brk  = (r_data == 9'd0) && !r_par_bit && w_frm;
    w_word = {w_brk, w_frm, r_par_err, r_data};
  end

  // Frame datapath; everything is re-initialised at start detect, so an abort needs no cleanup.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s7 <= 1'b1; r_s8 <= 1'b1;
      r_nbits <= 4'd8; r_par_en <= 1'b0; r_par_odd <= 1'b0; r_two_stop <= 1'b0;
      r_data <= '0; r_bit_cnt <= '0; r_par_acc <= 1'b0; r_par_bit <= 1'b0;
      r_par_err <= 1'b0; r_frm <= 1'b0; r_stop_cnt <= 1'b0;
    end else begin
      if (w_start_det) begin
        r_nbits    <= (n_data_bits_i >= 4'd5 && n_data_bits_i <= 4'd9) ? n_data_bits_i : 4'd8;
        r_par_en   <= (parity_mode_i == 2'b01) || (parity_mode_i == 2'b10);
        r_par_odd  <= (parity_mode_i == 2'b10);
        r_two_stop <= (n_stop_bits_i == 2'b10);
        r_data <= '0; r_bit_cnt <= '0; r_par_acc <= 1'b0; r_par_bit <= 1'b0;
        r_par_err <= 1'b0; r_frm <= 1'b0; r_stop_cnt <= 1'b0;
      end
      if (w_t7) r_s7 <= r_rx_sync;
      if (w_t8) r_s8 <= r_rx_sync;
      if (r_state == S_DATA && w_t9) begin
        r_data[r_bit_cnt] <= w_maj;
        r_par_acc         <= r_par_acc ^ w_maj;
        r_bit_cnt         <= r_bit_cnt + 4'd1;
      end
      if (r_state == S_PARITY && w_t9) begin
        r_par_bit <= w_maj;
        r_par_err <= (r_par_acc ^ w_maj) != r_par_odd;
      end
      if (r_state == S_STOP && w_t9 && !w_maj) r_frm <= 1'b1;
      if (r_state == S_STOP && w_t15) r_stop_cnt <= 1'b1;
    end
  end

  logic [11:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_ovr;
  logic          w_full, w_pop, w_wr, w_ovr_set;
  logic [11:0]   w_head;

  assign w_full    = (r_level == LW'(FIFO_DEPTH));
  assign w_pop     = out_vld_o && out_rdy_i;
  // A pop frees the head slot in the same cycle, so a full FIFO can still take the push.
  assign w_wr      = w_push && (!w_full || w_pop);
  assign w_ovr_set = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_wr && !rst) r_mem[r_wr_ptr] <= w_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovr    <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      r_ovr <= w_ovr_set | (r_ovr & ~clr_overrun_i);
    end
  end

  assign w_head       = r_mem[r_rd_ptr];
  assign out_vld_o    = (r_level != '0);
  assign out_dat_o    = out_vld_o ? w_head[8:0]  : 9'd0;
  assign out_err_o    = out_vld_o ? w_head[11:9] : 3'd0;
  assign fifo_level_o = r_level;
  assign overrun_o    = r_ovr;

endmodule

// File: tb/tb_prmcu_uart_rx_os.sv
// Directed bench for prmcu_uart_rx_os: divider 4 gives 80-clock bits; each test
// drives serial frames bit by bit and checks the FIFO output against hand values.
module tb_prmcu_uart_rx_os;
  logic        clk = 1'b0;
  logic        rst;
  logic        rx_en;
  logic [3:0]  n_data_bits_i;
  logic [1:0]  parity_mode_i;
  logic [1:0]  n_stop_bits_i;
  logic [15:0] clk_divider_i;
  logic        rx_i;
  logic [8:0]  out_dat_o;
  logic [2:0]  out_err_o;
  logic        out_vld_o;
  logic        out_rdy_i;
  logic [3:0]  fifo_level_o;
  logic        overrun_o;
  logic        clr_overrun_i;

  int n_vec = 0;
  int n_err = 0;
  int cnt;
  int first_vld;

  prmcu_uart_rx_os #(.FIFO_DEPTH(8), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .rx_en(rx_en), .n_data_bits_i(n_data_bits_i),
    .parity_mode_i(parity_mode_i), .n_stop_bits_i(n_stop_bits_i),
    .clk_divider_i(clk_divider_i), .rx_i(rx_i), .out_dat_o(out_dat_o),
    .out_err_o(out_err_o), .out_vld_o(out_vld_o), .out_rdy_i(out_rdy_i),
    .fifo_level_o(fifo_level_o), .overrun_o(overrun_o), .clr_overrun_i(clr_overrun_i)
  );

  always #5 clk = ~clk;

  // Holds one line level for ncyc clocks; must be entered on a falling edge.
  task automatic drive_bit(input logic b, input int ncyc);
    rx_i = b;
    repeat (ncyc) begin
      @(negedge clk);
      cnt++;
      if (first_vld < 0 && out_vld_o) first_vld = cnt;
    end
  endtask

  // pbit < 0 means no parity bit on the line.
  task automatic send_frame(input logic [8:0] d, input int nb, input int pbit, input int nst);
    @(negedge clk);
    cnt = 0;
    first_vld = -1;
    drive_bit(1'b0, 80);
    for (int i = 0; i < nb; i++) drive_bit(d[i], 80);
    if (pbit >= 0) drive_bit(pbit[0], 80);
    for (int i = 0; i < nst; i++) drive_bit(1'b1, 80);
  endtask

  task automatic pop_word(output logic v, output logic [8:0] d, output logic [2:0] e);
    v = out_vld_o;
    d = out_dat_o;
    e = out_err_o;
    out_rdy_i = 1'b1;
    @(negedge clk);
    out_rdy_i = 1'b0;
  endtask

  task automatic set_cfg(input logic [3:0] nb, input logic [1:0] pm, input logic [1:0] ns);
    n_data_bits_i = nb;
    parity_mode_i = pm;
    n_stop_bits_i = ns;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (out_vld_o !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %b want 0", out_vld_o); end
    n_vec++; if (out_dat_o !== 9'h000) begin n_err++; $display("FAIL reset_dat: got %h want 000", out_dat_o); end
    n_vec++; if (out_err_o !== 3'b000) begin n_err++; $display("FAIL reset_err: got %b want 000", out_err_o); end
    n_vec++; if (fifo_level_o !== 4'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", fifo_level_o); end
    n_vec++; if (overrun_o !== 1'b0) begin n_err++; $display("FAIL reset_ovr: got %b want 0", overrun_o); end
  endtask

  task automatic test_8n1;
    logic v; logic [8:0] d; logic [2:0] e;
    set_cfg(4'd8, 2'b00, 2'b01);
    send_frame(9'h0A5, 8, -1, 1);
    // Stop-bit tick 9 is tick 153 of the frame; with the 2-flop sync this lands vld on negedge 773.
    n_vec++; if (first_vld !== 773) begin n_err++; $display("FAIL 8n1_latency: vld at negedge %0d want 773", first_vld); end
    n_vec++; if (fifo_level_o !== 4'd1) begin n_err++; $display("FAIL 8n1_level: got %0d want 1", fifo_level_o); end
    pop_word(v, d, e);
    n_vec++; if (v !== 1'b1 || d !== 9'h0A5 || e !== 3'b000) begin
      n_err++; $display("FAIL 8n1_word: vld=%b dat=%h err=%b want 1/0a5/000", v, d, e); end
    n_vec++; if (out_vld_o !== 1'b0 || fifo_level_o !== 4'd0) begin
      n_err++; $display("FAIL 8n1_empty: vld=%b level=%0d want 0/0", out_vld_o, fifo_level_o); end
    $display("8n1: 0x0a5 popped, first vld at negedge %0d", first_vld);
  endtask

  task automatic test_parity;
    logic v; logic [8:0] d; logic [2:0] e;
    set_cfg(4'd7, 2'b01, 2'b10);
    send_frame(9'h055, 7, 1, 2);
    send_frame(9'h055, 7, 0, 2);
    repeat (20) @(negedge clk);
    n_vec++; if (fifo_level_o !== 4'd2) begin n_err++; $display("FAIL par_level: got %0d want 2", fifo_level_o); end
    pop_word(v, d, e);
    n_vec++; if (v !== 1'b1 || d !== 9'h055 || e !== 3'b001) begin
      n_err++; $display("FAIL par_bad: vld=%b dat=%h err=%b want 1/055/001", v, d, e); end
    pop_word(v, d, e);
    n_vec++; if (v !== 1'b1 || d !== 9'h055 || e !== 3'b000) begin
      n_err++; $display("FAIL par_good: vld=%b dat=%h err=%b want 1/055/000", v, d, e); end
    $display("parity: 7E2 wrong and right parity frames checked");
  endtask

  task automatic test_break;
    logic v; logic [8:0] d; logic [2:0] e;
    set_cfg(4'd8, 2'b00, 2'b01);
    @(negedge clk);
    rx_i = 1'b0;
    repeat (960) @(negedge clk);
    n_vec++; if (fifo_level_o !== 4'd1) begin n_err++; $display("FAIL brk_level_low: got %0d want 1", fifo_level_o); end
    rx_i = 1'b1;
    repeat (200) @(negedge clk);
    n_vec++; if (fifo_level_o !== 4'd1) begin n_err++; $display("FAIL brk_level_high: got %0d want 1", fifo_level_o); end
    pop_word(v, d, e);
    n_vec++; if (v !== 1'b1 || d !== 9'h000 || e !== 3'b110) begin
      n_err++; $display("FAIL brk_word: vld=%b dat=%h err=%b want 1/000/110", v, d, e); end
    $display("break: 12 bit times low gave one break word");
  endtask

  task automatic test_glitch;
    logic v; logic [8:0] d; logic [2:0] e;
    @(negedge clk);
    rx_i = 1'b0;
    repeat (30) @(negedge clk);
    rx_i = 1'b1;
    repeat (300) @(negedge clk);
    n_vec++; if (fifo_level_o !== 4'd0 || out_vld_o !== 1'b0) begin
      n_err++; $display("FAIL glitch_nopush: level=%0d vld=%b want 0/0", fifo_level_o, out_vld_o); end
    send_frame(9'h03C, 8, -1, 1);
    repeat (20) @(negedge clk);
    pop_word(v, d, e);
    n_vec++; if (v !== 1'b1 || d !== 9'h03C || e !== 3'b000) begin
      n_err++; $display("FAIL glitch_next: vld=%b dat=%h err=%b want 1/03c/000", v, d, e); end
    $display("glitch: 30-clock low ignored, following 0x03c received");
  endtask

  task automatic test_overrun;
    logic v; logic [8:0] d; logic [2:0] e;
    logic [8:0] exp_d;
    set_cfg(4'd8, 2'b00, 2'b01);
    for (int i = 0; i < 9; i++) begin
      exp_d = 9'(8'h11 * i + 8'h03);
      send_frame(exp_d, 8, -1, 1);
    end
    repeat (20) @(negedge clk);
    n_vec++; if (fifo_level_o !== 4'd8) begin n_err++; $display("FAIL ovr_level: got %0d want 8", fifo_level_o); end
    n_vec++; if (overrun_o !== 1'b1) begin n_err++; $display("FAIL ovr_flag: got %b want 1", overrun_o); end
    for (int i = 0; i < 8; i++) begin
      exp_d = 9'(8'h11 * i + 8'h03);
      pop_word(v, d, e);
      n_vec++; if (v !== 1'b1 || d !== exp_d || e !== 3'b000) begin
        n_err++; $display("FAIL ovr_word%0d: vld=%b dat=%h err=%b want 1/%h/000", i, v, d, e, exp_d); end
    end
    n_vec++; if (out_vld_o !== 1'b0 || overrun_o !== 1'b1) begin
      n_err++; $display("FAIL ovr_drained: vld=%b ovr=%b want 0/1", out_vld_o, overrun_o); end
    clr_overrun_i = 1'b1;
    @(negedge clk);
    clr_overrun_i = 1'b0;
    n_vec++; if (overrun_o !== 1'b0) begin n_err++; $display("FAIL ovr_clear: got %b want 0", overrun_o); end
    $display("overrun: 9 frames sent, 8 kept in order, flag cleared");
  endtask

  task automatic test_abort;
    logic v; logic [8:0] d; logic [2:0] e;
    set_cfg(4'd9, 2'b10, 2'b01);
    @(negedge clk);
    cnt = 0;
    first_vld = -1;
    drive_bit(1'b0, 80);
    drive_bit(1'b0, 80);
    drive_bit(1'b1, 80);
    drive_bit(1'b0, 80);
    drive_bit(1'b1, 80);
    drive_bit(1'b0, 40);
    rx_en = 1'b0;
    rx_i  = 1'b1;
    repeat (5) @(negedge clk);
    rx_en = 1'b1;
    repeat (200) @(negedge clk);
    n_vec++; if (fifo_level_o !== 4'd0) begin n_err++; $display("FAIL abort_nopush: level=%0d want 0", fifo_level_o); end
    send_frame(9'h1FF, 9, 0, 1);
    repeat (20) @(negedge clk);
    n_vec++; if (fifo_level_o !== 4'd1) begin n_err++; $display("FAIL abort_level: got %0d want 1", fifo_level_o); end
    pop_word(v, d, e);
    n_vec++; if (v !== 1'b1 || d !== 9'h1FF || e !== 3'b000) begin
      n_err++; $display("FAIL abort_word: vld=%b dat=%h err=%b want 1/1ff/000", v, d, e); end
    $display("abort: partial frame dropped, 9O1 0x1ff received");
  endtask

  task automatic test_reset_midframe;
    set_cfg(4'd8, 2'b00, 2'b01);
    @(negedge clk);
    cnt = 0;
    first_vld = -1;
    drive_bit(1'b0, 80);
    drive_bit(1'b1, 80);
    drive_bit(1'b0, 80);
    rst  = 1'b1;
    rx_i = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (800) @(negedge clk);
    n_vec++; if (fifo_level_o !== 4'd0 || out_vld_o !== 1'b0) begin
      n_err++; $display("FAIL rst_mid: level=%0d vld=%b want 0/0", fifo_level_o, out_vld_o); end
    $display("reset mid-frame: frame discarded");
  endtask

  initial begin
    rst = 1'b1;
    rx_en = 1'b1;
    rx_i = 1'b1;
    out_rdy_i = 1'b0;
    clr_overrun_i = 1'b0;
    clk_divider_i = 16'd4;
    n_data_bits_i = 4'd8;
    parity_mode_i = 2'b00;
    n_stop_bits_i = 2'b01;
    cnt = 0;
    first_vld = -1;
    test_reset;
    test_8n1;
    test_parity;
    test_break;
    test_glitch;
    test_overrun;
    test_abort;
    test_reset_midframe;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/prmcu_uart_rx_os.md
PRMCU_UART_RX_OS -- requirements
Module: prmcu_uart_rx_os

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, receive FIFO word count; power of two, 2..64.
REQ-002 Parameter DIV_W, default 16, width of the oversample clock divider.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 rx_en  input  1  receiver enable; low aborts any frame in progress.
REQ-006 n_data_bits_i  input  4  data bits per frame, 5..9; values outside that range are treated as 8.
REQ-007 parity_mode_i  input  2  00 none, 01 even, 10 odd, 11 treated as none.
REQ-008 n_stop_bits_i  input  2  01 one stop bit, 10 two stop bits, others treated as one.
REQ-009 clk_divider_i  input  DIV_W  oversample tick period is clk_divider_i+1 clocks; 16 ticks per bit.
REQ-010 rx_i  input  1  asynchronous serial line, idle high.
REQ-011 out_dat_o  output  9  received data, LSB-aligned, zero-extended above n_data_bits_i.
REQ-012 out_err_o  output  3  [0] parity error, [1] framing error, [2] break; travels with out_dat_o.
REQ-013 out_vld_o  output  1  FIFO head valid.
REQ-014 out_rdy_i  input  1  consumer ready; a word pops when out_vld_o and out_rdy_i are both high.
REQ-015 fifo_level_o  output  $clog2(FIFO_DEPTH)+1  words currently held.
REQ-016 overrun_o  output  1  sticky flag: a frame was dropped because the FIFO was full.
REQ-017 clr_overrun_i  input  1  clears overrun_o.

Function
REQ-018 rx_i SHALL pass through a 2-flop synchronizer whose flops reset to 1; all sampling uses the synchronized value.
REQ-019 The tick counter SHALL run only while rx_en=1 and the FSM is not IDLE; it reloads at start detect, so the first tick comes clk_divider_i+1 clocks after the falling edge.
REQ-020 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-021 IDLE->START on a synchronized 1->0 transition with rx_en=1; n_data_bits_i, parity_mode_i and n_stop_bits_i are latched on that cycle and are ignored mid-frame.
REQ-022 Each bit value SHALL be the 2-of-3 majority of samples at ticks 7, 8 and 9 of its 16-tick period.
REQ-023 START: a majority of 1 is a false start -> IDLE with no push; a majority of 0 -> DATA at tick 15.
REQ-024 DATA: bits are shifted LSB first; after the latched count of bits -> PARITY if parity is enabled, else STOP.
REQ-025 PARITY: error = (XOR of data bits XOR received bit) differs from 0 for even parity or from 1 for odd parity.
REQ-026 STOP: each stop bit is sampled by majority; a 0 on any stop bit sets the framing error.
REQ-027 Break SHALL be flagged when all data bits are 0, the parity bit (if present) is 0, and the framing error is set.
REQ-028 The frame SHALL be pushed on the cycle of the last stop bit's tick-9 sample, and the FSM returns to IDLE that same cycle; the next start bit can be detected during the second half of the stop bit.
REQ-029 Push-to-out_vld_o latency SHALL be 1 clock into an empty FIFO; the FIFO is first-word-fall-through with no bubbles.
REQ-030 A full FIFO with a pop in the same cycle SHALL accept the push; a full FIFO without a pop drops the frame and sets overrun_o.
REQ-031 A simultaneous overrun set and clr_overrun_i SHALL leave overrun_o at 1.
REQ-032 Pop on an empty FIFO SHALL be ignored; fifo_level_o never wraps.
REQ-033 rx_en falling mid-frame SHALL return the FSM to IDLE within 1 clock and discard the partial frame; FIFO contents and overrun_o are kept.
REQ-034 rx_en=0 SHALL not block the pop side.

Reset
REQ-035 With rst=1 at a rising edge: FSM=IDLE, counters=0, synchronizer=1, FIFO empty, out_vld_o=0, out_dat_o=0, out_err_o=0, fifo_level_o=0, overrun_o=0.
REQ-036 Reset mid-frame SHALL discard the frame; no push occurs on the cycle rst is high.

Verification
REQ-037 clk_divider_i=4 (80-clock bits), 8N1, send 0xA5 -> one word 0x0A5 with err=000, out_vld_o high 1 clock after the stop-bit tick-9 sample.
REQ-038 7 data bits, even parity, 2 stop bits, send 0x55 with a wrong parity bit -> 0x055 with err=001; then with a correct parity bit -> err=000.
REQ-039 Line held low for 12 bit times in 8N1 -> 0x000 with err=110; no second frame until the line returns high and falls again.
REQ-040 Low glitch of 30 clocks with divider 4 -> false start, no push, FSM back in IDLE.
REQ-041 out_rdy_i=0 while sending FIFO_DEPTH+1 frames -> fifo_level_o=8, overrun_o=1, the first 8 words are intact in order; clr_overrun_i clears the flag.
REQ-042 rx_en dropped at bit 4 of a frame, then the next full 9O1 frame 0x1FF -> only 0x1FF with err=000 is received.
